// File: rtl/store_tally.sv
// Checkout accumulator: adds a looked-up two-digit BCD price into a 4-digit BCD
// total one digit per cycle, and keeps a saturating 2-digit BCD item count.
//
// state  | meaning
// IDLE   | waiting for an accepted add edge
// ADD    | adding digit d of the latched price into the working accumulator
// COMMIT | copying accumulator (or 9999 on carry-out) to the visible total
module store_tally (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] item,
  input  logic       add,
  input  logic       clear,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] bcd4,
  output logic [3:0] bcd5,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t      state;
  logic        add_s1, add_s2, add_prev;
  logic        accept;
  logic [7:0]  price_lut;
  logic [7:0]  price;
  logic [15:0] total;
  logic [15:0] acc;
  logic [15:0] acc_upd;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic [1:0]  d;
  logic        carry;
  logic [3:0]  acc_dig;
  logic [3:0]  addend;
  logic [4:0]  sum;
  logic [3:0]  dig_next;
  logic        carry_next;

  // Synchroniser is deliberately untouched by clear so a held add is not re-accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_s1   <= 1'b0;
      add_s2   <= 1'b0;
      add_prev <= 1'b0;
    end else begin
      add_s1   <= add;
      add_s2   <= add_s1;
      add_prev <= add_s2;
    end
  end

  assign accept = add_s2 & ~add_prev;

  always_comb begin
    price_lut = 8'h00;
    case (item)
      3'd0: price_lut = 8'h05;
      3'd1: price_lut = 8'h12;
      3'd2: price_lut = 8'h20;
      3'd3: price_lut = 8'h35;
      3'd4: price_lut = 8'h49;
      3'd5: price_lut = 8'h60;
      3'd6: price_lut = 8'h75;
      3'd7: price_lut = 8'h99;
      default: price_lut = 8'h00;
    endcase
  end

  always_comb begin
    acc_dig = 4'd0;
    addend  = 4'd0;
    case (d)
      2'd0: begin acc_dig = acc[3:0];   addend = price[3:0]; end
      2'd1: begin acc_dig = acc[7:4];   addend = price[7:4]; end
      2'd2: acc_dig = acc[11:8];
      2'd3: acc_dig = acc[15:12];
      default: acc_dig = 4'd0;
    endcase
    sum = {1'b0, acc_dig} + {1'b0, addend} + {4'd0, carry};
    if (sum > 5'd9) begin
      dig_next   = sum[3:0] + 4'd6;
      carry_next = 1'b1;
    end else begin
      dig_next   = sum[3:0];
      carry_next = 1'b0;
    end
  end

  always_comb begin
    acc_upd = acc;
    case (d)
      2'd0: acc_upd[3:0]   = dig_next;
      2'd1: acc_upd[7:4]   = dig_next;
      2'd2: acc_upd[11:8]  = dig_next;
      2'd3: acc_upd[15:12] = dig_next;
      default: acc_upd = acc;
    endcase
  end

  always_comb begin
    cnt_next = cnt;
    if (cnt == 8'h99)
      cnt_next = cnt;
    else if (cnt[3:0] == 4'd9)
      cnt_next = {cnt[7:4] + 4'd1, 4'd0};
    else
      cnt_next = {cnt[7:4], cnt[3:0] + 4'd1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      price <= 8'h00;
      total <= 16'h0000;
      acc   <= 16'h0000;
      cnt   <= 8'h00;
      d     <= 2'd0;
      carry <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      total <= 16'h0000;
      acc   <= 16'h0000;
      cnt   <= 8'h00;
      d     <= 2'd0;
      carry <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            price <= price_lut;
            acc   <= total;
            d     <= 2'd0;
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          acc   <= acc_upd;
          carry <= carry_next;
          if (d == 2'd3)
            state <= COMMIT;
          else
            d <= d + 2'd1;
        end
        COMMIT: begin
          // Carry out of the thousands digit means the total passed 9999.
          if (carry) begin
            total <= 16'h9999;
            ovf   <= 1'b1;
          end else begin
            total <= acc;
          end
          cnt   <= cnt_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bcd0 = total[3:0];
  assign bcd1 = total[7:4];
  assign bcd2 = total[11:8];
  assign bcd3 = total[15:12];
  assign bcd4 = cnt[3:0];
  assign bcd5 = cnt[7:4];

endmodule

// File: tb/tb_store_tally.sv
// Directed bench for store_tally: totals and counts are hand-computed BCD values.
module tb_store_tally;

  logic       clk;
  logic       rst_n;
  logic [2:0] item;
  logic       add;
  logic       clear;
  logic [3:0] bcd0, bcd1, bcd2, bcd3, bcd4, bcd5;
  logic       busy;
  logic       ovf;

  int n_chk;
  int n_pass;
  int hexbad;
  int busy_cycles;
  logic [15:0] snap6, snap7;

  store_tally dut (
    .clk   (clk),
    .rst_n (rst_n),
    .item  (item),
    .add   (add),
    .clear (clear),
    .bcd0  (bcd0),
    .bcd1  (bcd1),
    .bcd2  (bcd2),
    .bcd3  (bcd3),
    .bcd4  (bcd4),
    .bcd5  (bcd5),
    .busy  (busy),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] tot();
    return {bcd3, bcd2, bcd1, bcd0};
  endfunction

  function automatic logic [7:0] cnt();
    return {bcd5, bcd4};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clean add: edge on add, observe 12 cycles, release, let the synchroniser settle.
  task automatic press(input logic [2:0] it);
    item = it;
    add  = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (i == 6) snap6 = tot();
      if (i == 7) snap7 = tot();
    end
    add = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bcd0 > 4'd9 || bcd1 > 4'd9 || bcd2 > 4'd9 || bcd3 > 4'd9 ||
        bcd4 > 4'd9 || bcd5 > 4'd9)
      hexbad++;
  end

  initial begin
    n_chk = 0; n_pass = 0; hexbad = 0;
    rst_n = 1'b0; item = 3'd0; add = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_total", tot(), 16'h0000);
    chk("rst_count", cnt(), 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    // simple adds with latency and busy width
    press(3'd3);
    chk("add1_busy_cycles", busy_cycles, 5);
    chk("add1_before_e7", snap6, 16'h0000);
    chk("add1_after_e7", snap7, 16'h0035);
    press(3'd3);
    chk("add2_total", tot(), 16'h0070);
    chk("add2_count", cnt(), 8'h02);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_total", tot(), 16'h0000);
    chk("async_rst_count", cnt(), 8'h00);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // BCD carry chain
    press(3'd7);
    chk("carry_99", tot(), 16'h0099);
    press(3'd1);
    chk("carry_total", tot(), 16'h0111);
    chk("carry_count", cnt(), 8'h02);

    // saturation
    do_clear();
    chk("clr_total", tot(), 16'h0000);
    for (int k = 0; k < 100; k++) press(3'd7);
    chk("sat100_total", tot(), 16'h9900);
    chk("sat100_count", cnt(), 8'h99);
    press(3'd7);
    chk("sat101_total", tot(), 16'h9999);
    chk("sat101_count", cnt(), 8'h99);
    chk("sat101_ovf", ovf, 1'b0);
    press(3'd7);
    chk("ovf_total", tot(), 16'h9999);
    chk("ovf_count", cnt(), 8'h99);
    chk("ovf_flag", ovf, 1'b1);
    press(3'd0);
    chk("ovf_sticky_total", tot(), 16'h9999);
    chk("ovf_sticky_flag", ovf, 1'b1);
    do_clear();
    chk("clr2_total", tot(), 16'h0000);
    chk("clr2_count", cnt(), 8'h00);
    chk("clr2_ovf", ovf, 1'b0);

    // held add gives exactly one accept
    item = 3'd2;
    add  = 1'b1;
    repeat (50) @(negedge clk);
    add = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_total", tot(), 16'h0020);
    chk("hold_count", cnt(), 8'h01);

    // second edge arriving while busy is dropped
    item = 3'd1;
    add  = 1'b1;
    repeat (3) @(negedge clk);
    chk("drop_busy", busy, 1'b1);
    add = 1'b0;
    repeat (2) @(negedge clk);
    add = 1'b1;
    repeat (15) @(negedge clk);
    add = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_total", tot(), 16'h0032);
    chk("drop_count", cnt(), 8'h02);

    // clear sampled at E4 abandons the add; held add is not re-accepted
    item = 3'd5;
    add  = 1'b1;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("abort_clr_total", tot(), 16'h0000);
    chk("abort_clr_count", cnt(), 8'h00);
    chk("abort_clr_busy", busy, 1'b0);
    repeat (15) @(negedge clk);
    add = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_clr_nocommit", tot(), 16'h0000);
    chk("abort_clr_nocount", cnt(), 8'h00);

    // reset low before E5 abandons the add
    press(3'd4);
    chk("pre_rst_total", tot(), 16'h0049);
    item = 3'd5;
    add  = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    add   = 1'b0;
    #1;
    chk("abort_rst_total", tot(), 16'h0000);
    chk("abort_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_rst_nocommit", tot(), 16'h0000);
    chk("abort_rst_count", cnt(), 8'h00);

    chk("digit_range", hexbad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/store_tally.md
# store_tally

Sequential checkout accumulator for the department-store board design. It sits directly upstream of the six `seg7` BCD decoders. It takes a 3-bit item code and an "add" request, looks up the item's two-digit BCD price, and adds that price into a 4-digit BCD running total using a digit-serial adder. It also keeps a 2-digit BCD item count and presents all six digits as BCD nibbles, one per HEX display.

## Interface
- No parameters. The price table is fixed: code 0→05, 1→12, 2→20, 3→35, 4→49, 5→60, 6→75, 7→99 (BCD).

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `item` input 3: item code, from SW[2:0]. Sampled in the cycle the add is accepted.
- `add` input 1: asynchronous level, from a switch or key. Each rising edge requests one add.
- `clear` input 1: synchronous, active-high. Zeroes the total, the count and `ovf`.
- `bcd0..bcd3` output 4 each: total digits, ones..thousands. Drive HEX0..HEX3.
- `bcd4, bcd5` output 4 each: item count, ones and tens. Drive HEX4, HEX5.
- `busy` output 1: high while an add is in progress.
- `ovf` output 1: sticky flag, set when the total saturates.

## Operation
- **Input synchronisation:** `add` passes through a 2-flop synchroniser, then a third flop (`add_prev`). The accept pulse is `add_s2 & ~add_prev`.
  - A held-high `add` produces exactly one accept.
  - An accept that arrives while `busy` is high is dropped, not queued.
- **Shadow registers:** the total and count are held in two shadow registers: the visible register and the working accumulator.
- **FSM states:** IDLE, ADD, COMMIT.
  - IDLE: on an accept, latch `item` and its price, copy the visible total into the accumulator, set digit index `d`=0 and carry=0, go to ADD.
  - ADD: one BCD digit per cycle, `d`=0..3.
    - Addend digit is price[d] for `d`<2, and 0 for `d`≥2.
    - Raw sum = acc[d] + addend + carry. If the raw sum > 9: digit = sum+6 (low nibble) and carry=1; otherwise carry=0.
    - When `d`=3, go to COMMIT.
  - COMMIT: one cycle.
    - If carry=1 (sum > 9999): visible total ← 9999 and `ovf` ← 1.
    - Otherwise: visible total ← accumulator.
    - Count increments in BCD and saturates at 99.
    - Return to IDLE.
- **No partial results:** the visible digits never show a partially added total.
- **`clear`:** has priority over everything.
  - In any state, it forces IDLE, zeroes the visible total, accumulator, count and `ovf`, and abandons any in-flight add.
  - It does not reset the synchronisers, so an `add` already high during `clear` is not re-accepted.
- **Saturated total:** once saturated at 9999, further adds keep 9999 and still increment the count.
- **Digit range:** all output digits are always in 0–9. Values A–F never appear.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - All BCD outputs = 0, `busy`=0, `ovf`=0, FSM = IDLE.
  - All synchroniser flops = 0, so an `add` held high through reset is accepted once after release.
- **Reset mid-add:** aborts the add immediately. Nothing is committed.
- **Latency:** let edge E0 be the first edge at which `add` is sampled high.
  - Accept pulse is high between E1 and E2.
  - IDLE→ADD at E2. Digits 0–3 are processed at E3–E6. COMMIT executes at E7.
  - New digits, count and `ovf` are visible after E7.
- **`busy`:** high after E2 through E7, low after E7, i.e. 5 cycles.
  - A new accept is honoured in the cycle after `busy` falls.
- **`clear` timing:** `clear` sampled high at edge C gives zeroed outputs and `busy`=0 after C.
- **Throughput:** at most one add per 6 cycles.

## Test plan
1. **Reset:** pulse `rst_n` low mid-cycle → all digits 0, `busy`=0, `ovf`=0, asynchronously and before the next clock edge.
2. **Simple adds:** `item`=3, toggle `add` twice with idle gaps → total 0070, count 02. `busy` is high for exactly 5 cycles per add, and results appear at E7.
3. **BCD carry chain:** adds of item 7 then item 1 → total 0111, count 02. No A–F digit ever appears on any output.
4. **Overflow and count saturation:** 101 adds of item 7 → total 9999, count 99, `ovf`=0. One more add → total 9999, count 99, `ovf`=1. Then `clear` → 0000, count 00, `ovf`=0.
5. **Edge behaviour:** hold `add` high for 50 cycles → exactly one add. Raise a second `add` edge during `busy` → it is ignored and the count rises by 1 only.
6. **Abort paths:** assert `clear` at E4 of an add → outputs 0 after that edge, no commit. Repeat with `rst_n` low at E5 → same result.
